// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM refresh scheduler: command encoding, scheduler
// states and the refresh postpone limit.
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_NOP           = 2'd0,
    CMD_PRECHARGE_ALL = 2'd1,
    CMD_AUTO_REFRESH  = 2'd2,
    CMD_LOAD_MODE     = 2'd3
  } sdram_cmd_t;

  typedef enum logic [3:0] {
    ST_PWRUP     = 4'd0,
    ST_INIT_PRE  = 4'd1,
    ST_INIT_TRP  = 4'd2,
    ST_INIT_REF  = 4'd3,
    ST_INIT_TRFC = 4'd4,
    ST_INIT_MRS  = 4'd5,
    ST_INIT_TMRD = 4'd6,
    ST_IDLE      = 4'd7,
    ST_ACCESS    = 4'd8,
    ST_REF       = 4'd9,
    ST_TRFC_WAIT = 4'd10
  } sched_state_t;

  localparam int unsigned PEND_W       = 4;
  localparam int unsigned MAX_POSTPONE = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A10 selects all banks for PRECHARGE; LOAD MODE carries the mode word.
  function automatic logic [12:0] cmd_addr(input sdram_cmd_t c, input logic [12:0] mode_word);
    case (c)
      CMD_PRECHARGE_ALL: cmd_addr = 13'h0400;
      CMD_LOAD_MODE:     cmd_addr = mode_word;
      default:           cmd_addr = 13'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval down-counter with a saturating count of owed refreshes
// and a sticky overflow flag.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 195
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              issue_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int unsigned       CNT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              tick_s;

  always_comb begin
    tick_s = run_i && (cnt_q == '0);
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (run_i) begin
      cnt_d = tick_s ? RELOAD : cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    // A tick and an issued refresh in the same cycle cancel out.
    if (tick_s && !issue_i) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!tick_s && issue_i && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= RELOAD;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Power-up sequencing, periodic AUTO REFRESH and arbitration of the SDRAM
// command bus between refresh and the Zorro III access sequencer.
module sdram_refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int unsigned INIT_WAIT        = 5000,
  parameter int unsigned REFRESH_INTERVAL = 195,
  parameter int unsigned INIT_REFRESHES   = 8,
  parameter int unsigned TRP              = 1,
  parameter int unsigned TRFC             = 3,
  parameter int unsigned TMRD             = 2,
  parameter int unsigned URGENT           = 4,
  parameter logic [12:0] MODE_WORD        = 13'h020
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        access_req,
  input  logic        access_done,
  output logic        grant,
  output logic [1:0]  cmd,
  output logic [12:0] ma,
  output logic        cke,
  output logic        init_done,
  output logic [3:0]  refresh_pending,
  output logic        refresh_overflow
);

  localparam int unsigned WAIT_MAX = max_u(max_u(INIT_WAIT, TRP), max_u(TRFC, TMRD));
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int unsigned RC_W     = $clog2(INIT_REFRESHES + 1);

  // Wait states assume TRP, TRFC and TMRD are at least 1.
  localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0]  CKE_ON     = CNT_W'((INIT_WAIT >= 2) ? INIT_WAIT - 2 : 0);
  localparam logic [CNT_W-1:0]  TRP_LAST   = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0]  TRFC_LAST  = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0]  TMRD_LAST  = CNT_W'(TMRD - 1);
  localparam logic [RC_W-1:0]   INIT_REFS  = RC_W'(INIT_REFRESHES);
  localparam logic [PEND_W-1:0] URGENT_L   = PEND_W'(URGENT);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              init_done_q, init_done_d;
  logic              grant_q, grant_d;
  sdram_cmd_t        cmd_q, cmd_d;
  logic [12:0]       ma_q, ma_d;
  logic              cke_q, cke_d;
  logic [PEND_W-1:0] pend_s;
  logic              ovf_s;
  logic              ref_issue_s;
  logic              urgent_s;

  assign ref_issue_s = (state_q == ST_REF);
  assign urgent_s    = (pend_s >= URGENT_L);

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .run_i      (init_done_q),
    .issue_i    (ref_issue_s),
    .pending_o  (pend_s),
    .overflow_o (ovf_s)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      init_done_q <= 1'b0;
      grant_q     <= 1'b0;
      cmd_q       <= CMD_NOP;
      ma_q        <= 13'h0000;
      cke_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      init_done_q <= init_done_d;
      grant_q     <= grant_d;
      cmd_q       <= cmd_d;
      ma_q        <= ma_d;
      cke_q       <= cke_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = ST_INIT_PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT_PRE: begin
        state_d = ST_INIT_TRP;
        cnt_d   = '0;
      end
      ST_INIT_TRP: begin
        if (cnt_q == TRP_LAST) begin
          state_d = ST_INIT_REF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT_REF: begin
        state_d = ST_INIT_TRFC;
        cnt_d   = '0;
        rcnt_d  = rcnt_q + 1'b1;
      end
      ST_INIT_TRFC: begin
        if (cnt_q == TRFC_LAST) begin
          cnt_d   = '0;
          state_d = (rcnt_q == INIT_REFS) ? ST_INIT_MRS : ST_INIT_REF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT_MRS: begin
        state_d = ST_INIT_TMRD;
        cnt_d   = '0;
      end
      ST_INIT_TMRD: begin
        if (cnt_q == TMRD_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (access_req && !urgent_s) begin
          state_d = ST_ACCESS;
        end else if (pend_s != '0) begin
          state_d = ST_REF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (access_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_REF: begin
        state_d = ST_TRFC_WAIT;
        cnt_d   = '0;
      end
      ST_TRFC_WAIT: begin
        // Chain straight into the next refresh unless an access may go first.
        if (cnt_q == TRFC_LAST) begin
          cnt_d = '0;
          if ((pend_s != '0) && (urgent_s || !access_req)) begin
            state_d = ST_REF;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
        rcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    cmd_d   = CMD_NOP;
    grant_d = 1'b0;
    cke_d   = 1'b1;
    case (state_d)
      ST_PWRUP:                cke_d   = (cnt_d >= CKE_ON);
      ST_INIT_PRE:             cmd_d   = CMD_PRECHARGE_ALL;
      ST_INIT_REF, ST_REF:     cmd_d   = CMD_AUTO_REFRESH;
      ST_INIT_MRS:             cmd_d   = CMD_LOAD_MODE;
      ST_ACCESS:               grant_d = 1'b1;
      default:                 cmd_d   = CMD_NOP;
    endcase
    ma_d = cmd_addr(cmd_d, MODE_WORD);
  end

  assign grant            = grant_q;
  assign cmd              = cmd_q;
  assign ma               = ma_q;
  assign cke              = cke_q;
  assign init_done        = init_done_q;
  assign refresh_pending  = pend_s;
  assign refresh_overflow = ovf_s;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Self-checking bench: init schedule table, directed arbitration corners and
// randomized request traffic against a cycle-level reference model.
module tb_sdram_refresh_scheduler;

  localparam int P_WAIT   = 10;
  localparam int P_INT    = 20;
  localparam int P_NREF   = 8;
  localparam int P_TRP    = 1;
  localparam int P_TRFC   = 3;
  localparam int P_TMRD   = 2;
  localparam int P_URGENT = 4;
  localparam int R0       = P_WAIT + 1 + P_TRP;
  localparam int MRS_AT   = R0 + P_NREF * (1 + P_TRFC);
  localparam int T_DONE   = MRS_AT + 1 + P_TMRD;

  localparam logic [1:0] C_NOP = 2'd0;
  localparam logic [1:0] C_PRE = 2'd1;
  localparam logic [1:0] C_AR  = 2'd2;
  localparam logic [1:0] C_MRS = 2'd3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        access_req = 1'b0;
  logic        access_done = 1'b0;
  logic        grant;
  logic [1:0]  cmd;
  logic [12:0] ma;
  logic        cke;
  logic        init_done;
  logic [3:0]  refresh_pending;
  logic        refresh_overflow;

  sdram_refresh_scheduler #(
    .INIT_WAIT(P_WAIT), .REFRESH_INTERVAL(P_INT), .INIT_REFRESHES(P_NREF),
    .TRP(P_TRP), .TRFC(P_TRFC), .TMRD(P_TMRD), .URGENT(P_URGENT), .MODE_WORD(13'h020)
  ) dut (
    .CLK(CLK), .RESET(RESET), .access_req(access_req), .access_done(access_done),
    .grant(grant), .cmd(cmd), .ma(ma), .cke(cke), .init_done(init_done),
    .refresh_pending(refresh_pending), .refresh_overflow(refresh_overflow)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state: expected outputs of the current cycle.
  int         m_pend;
  bit         m_ovf;
  bit         m_grant;
  logic [1:0] m_cmd;
  int         m_busy;

  typedef struct {
    int          cyc;
    logic        req;
    logic [1:0]  cmd;
    logic [12:0] ma;
    logic        cke;
    logic        idone;
    logic [3:0]  pend;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [12:0] ma_of(input logic [1:0] c);
    if (c == C_PRE) return 13'h0400;
    if (c == C_MRS) return 13'h0020;
    return 13'h0000;
  endfunction

  function automatic logic [1:0] init_cmd(input int c);
    if (c == P_WAIT) return C_PRE;
    if (c >= R0 && c < MRS_AT && ((c - R0) % (1 + P_TRFC)) == 0) return C_AR;
    if (c == MRS_AT) return C_MRS;
    return C_NOP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sample();
    logic [22:0] exp;
    logic [1:0]  ec;
    @(negedge CLK);
    if (cyc < T_DONE) begin
      ec  = init_cmd(cyc);
      exp = {1'b0, ec, ma_of(ec), (cyc >= P_WAIT - 2), 1'b0, 4'd0, 1'b0};
    end else begin
      exp = {m_grant, m_cmd, ma_of(m_cmd), 1'b1, 1'b1, 4'(m_pend), m_ovf};
    end
    check("outputs{grant,cmd,ma,cke,init_done,pend,ovf}",
          32'({grant, cmd, ma, cke, init_done, refresh_pending, refresh_overflow}), 32'(exp));
  endtask

  task automatic model_step(input logic req, input logic done);
    bit         tick, issue, no, ng;
    int         np, nb;
    logic [1:0] nc;
    tick  = ((cyc - T_DONE) % P_INT) == P_INT - 1;
    issue = (m_cmd == C_AR);
    np = m_pend;
    no = m_ovf;
    if (tick && !issue) begin
      if (m_pend == 8) no = 1'b1;
      else np = m_pend + 1;
    end else if (issue && !tick) begin
      np = m_pend - 1;
    end
    ng = m_grant;
    nc = C_NOP;
    nb = m_busy;
    if (m_grant) begin
      if (done) ng = 1'b0;
    end else if (issue) begin
      nb = P_TRFC;
    end else if (m_busy > 0) begin
      nb = m_busy - 1;
      if (m_busy == 1 && m_pend > 0 && (m_pend >= P_URGENT || !req)) nc = C_AR;
    end else if (req && m_pend < P_URGENT) begin
      ng = 1'b1;
    end else if (m_pend > 0) begin
      nc = C_AR;
    end
    m_pend = np; m_ovf = no; m_grant = ng; m_cmd = nc; m_busy = nb;
  endtask

  task automatic advance(input logic req, input logic done, input logic rst);
    access_req  = req;
    access_done = done;
    RESET       = rst;
    if (rst) begin
      cyc = 0; m_pend = 0; m_ovf = 1'b0; m_grant = 1'b0; m_cmd = C_NOP; m_busy = 0;
    end else begin
      if (cyc >= T_DONE) model_step(req, done);
      cyc++;
    end
  endtask

  task automatic cycle(input logic req, input logic done, input logic rst);
    sample();
    advance(req, done, rst);
  endtask

  initial begin
    int n_ar, budget, ar_at, g_at, p_at, lvl;
    logic r_req, r_done, r_rst, cur_g;

    tbl[0]  = '{0,  1'b0, C_NOP, 13'h0000, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{7,  1'b0, C_NOP, 13'h0000, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{8,  1'b0, C_NOP, 13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{10, 1'b0, C_PRE, 13'h0400, 1'b1, 1'b0, 4'd0};
    tbl[4]  = '{11, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[5]  = '{12, 1'b0, C_AR,  13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[6]  = '{16, 1'b0, C_AR,  13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[7]  = '{40, 1'b0, C_AR,  13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[8]  = '{44, 1'b0, C_MRS, 13'h0020, 1'b1, 1'b0, 4'd0};
    tbl[9]  = '{46, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b0, 4'd0};
    tbl[10] = '{47, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b1, 4'd0};
    tbl[11] = '{66, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b1, 4'd0};
    tbl[12] = '{67, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b1, 4'd1};
    tbl[13] = '{68, 1'b0, C_AR,  13'h0000, 1'b1, 1'b1, 4'd1};
    tbl[14] = '{69, 1'b0, C_NOP, 13'h0000, 1'b1, 1'b1, 4'd0};

    @(negedge CLK);
    @(negedge CLK);
    advance(1'b0, 1'b0, 1'b1);

    // Power-up sequence and first periodic refresh against fixed checkpoints.
    for (int i = 0; i < 15; i++) begin
      while (cyc < tbl[i].cyc) cycle(tbl[i].req, 1'b0, 1'b0);
      sample();
      check($sformatf("table[%0d]{cmd,ma,cke,init_done,pend}", i),
            32'({cmd, ma, cke, init_done, refresh_pending}),
            32'({tbl[i].cmd, tbl[i].ma, tbl[i].cke, tbl[i].idone, tbl[i].pend}));
      advance(tbl[i].req, 1'b0, 1'b0);
    end

    // Long access: pending saturates, overflow sets, then a refresh burst.
    while (cyc < 312) cycle(cyc >= 100, 1'b0, 1'b0);
    sample();
    check("pending_saturated", 32'(refresh_pending), 32'd8);
    check("overflow_set", 32'(refresh_overflow), 32'd1);
    check("grant_held", 32'(grant), 32'd1);
    advance(1'b0, 1'b1, 1'b0);
    n_ar = 0;
    for (int i = 0; i < 31; i++) begin
      sample();
      if (cmd == C_AR) n_ar++;
      advance(1'b0, 1'b0, 1'b0);
    end
    check("burst_refresh_count", 32'(n_ar), 32'd8);
    sample();
    check("overflow_sticky", 32'(refresh_overflow), 32'd1);
    advance(1'b1, 1'b0, 1'b0);

    // Access ends with pending at URGENT while another request is waiting.
    budget = 0;
    while (!(m_pend == P_URGENT && m_grant) && budget < 400) begin
      cycle(1'b1, 1'b0, 1'b0);
      budget++;
    end
    check("reach_pending_urgent_in_budget", 32'(budget < 400), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    ar_at = -1; g_at = -1; p_at = -1;
    for (int i = 0; i < 25; i++) begin
      sample();
      if (cmd == C_AR && ar_at < 0) ar_at = i;
      if (grant && g_at < 0) begin g_at = i; p_at = refresh_pending; end
      advance(g_at < 0, 1'b0, 1'b0);
    end
    check("refresh_before_grant", 32'(ar_at >= 0 && g_at > ar_at), 32'd1);
    check("pending_at_grant", 32'(p_at), 32'd3);

    // Reset while granted, then again in the middle of init.
    sample();
    check("granted_before_reset", 32'(grant), 32'd1);
    advance(1'b0, 1'b0, 1'b1);
    sample();
    check("reset_clears{grant,cke,init_done,pend,ovf}",
          32'({grant, cke, init_done, refresh_pending, refresh_overflow}), 32'd0);
    advance(1'b0, 1'b0, 1'b0);
    while (cyc < 14) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Randomized traffic; requests are held until granted.
    r_req = 1'b0;
    lvl = 3;
    for (int k = 0; k < 3000; k++) begin
      cur_g = (cyc >= T_DONE) && m_grant;
      if (!r_req) begin
        r_req = ($urandom_range(0, 5) == 0);
        if (r_req) lvl = ($urandom_range(0, 1) == 0) ? 3 : 90;
      end else if (cur_g) begin
        r_req = $urandom_range(0, 1);
      end
      r_done = cur_g ? ($urandom_range(0, lvl) == 0) : ($urandom_range(0, 29) == 0);
      r_rst  = ($urandom_range(0, 1499) == 0);
      cycle(r_req, r_done, r_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
